router_ctrl_fsm_n: RTL and testbench
====================================

# router_ctrl_fsm_n

Parametrised write-side control FSM for an N-channel packet router. It sits between the byte-wide input port and the N output FIFOs, alongside the register block and the synchroniser. It decodes the header address and sequences header and payload loading, FIFO-full stalls, parity capture and per-channel soft reset. It adds invalid-address drop and an optional wait-till-empty timeout.

## Interface
- NCH, 3: number of output channels, 2..8.
- ADDR_W, 2: header address field width; must satisfy 2**ADDR_W >= NCH.
- TIMEOUT_CYC, 1023: wait-till-empty timeout in cycles. Used only with ROUTER_WAIT_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset: rst, synchronous, active-low; clock clk.
- pktvalid  in  1  source is driving packet bytes.
- din  in  ADDR_W  address field of the current input byte (header LSBs).
- fifofull  in  1  selected FIFO is full.
- fifoempty  in  NCH  per-channel FIFO empty.
- srst  in  NCH  per-channel soft reset from the read side.
- parity_done  in  1  register block has captured the parity byte.
- lowpktvalid  in  1  packet ended while in the full path.
- detect_add, lfd_state, ld_state, laf_state, full_state  out  1 each  state decodes.
- we_en_reg, rst_int_reg, busy  out  1 each  register-block controls.
- wr_sel  out  NCH  one-hot FIFO write select.
- addr_err  out  1  one-cycle pulse: invalid address dropped.
- timeout_err  out  1  one-cycle pulse: wait timed out. Tied 0 when the macro is undefined.

## Operation
- States: DECODE_ADD, LFD, LD, FFS, LAF, LP, CPERROR, WAIT_TILL_EMPTY, DROP. Binary encoded.
- Address register `addr`: loaded from din in DECODE_ADD when pktvalid. It holds until the FSM next returns to DECODE_ADD. All later decisions use `addr`; din is never used after DECODE_ADD.
- DECODE_ADD transitions, in priority order, when pktvalid:
  - din >= NCH: go to DROP and pulse addr_err.
  - fifoempty[din]: go to LFD.
  - otherwise: go to WAIT_TILL_EMPTY.
  - If pktvalid is low, stay in DECODE_ADD.
- LFD always goes to LD.
- LD: if fifofull, go to FFS. Otherwise, if !pktvalid, go to LP. Otherwise stay in LD.
- FFS: if !fifofull, go to LAF; otherwise stay.
- LAF, in priority order:
  - parity_done: go to DECODE_ADD.
  - lowpktvalid: go to LP.
  - otherwise: go to LD.
- LP always goes to CPERROR.
- CPERROR: if fifofull, go to FFS; otherwise go to DECODE_ADD.
- WAIT_TILL_EMPTY: if fifoempty[addr], go to LFD; otherwise stay.
- DROP: if !pktvalid, go to DECODE_ADD; otherwise stay. Bytes are discarded: busy=0 and we_en_reg=0.
- Output decodes (Moore, from the state register only):
  - detect_add = DECODE_ADD.
  - lfd_state, ld_state, laf_state, full_state = LFD, LD, LAF, FFS respectively.
  - rst_int_reg = CPERROR.
  - we_en_reg = LD | LAF | LP.
  - busy = LFD | FFS | LAF | LP | CPERROR | WAIT_TILL_EMPTY.
  - wr_sel = one-hot(addr) in LFD, LD, LAF, LP; 0 otherwise.
- Soft reset: if srst[addr] is high in any state other than DECODE_ADD, the next state is DECODE_ADD, addr is cleared to 0 and any timer is cleared. srst of other channels is ignored.
- Update priority: rst low, then srst[addr], then next-state logic.
- Unused encodings return to DECODE_ADD.

## Timing
- Reset values: state DECODE_ADD, addr 0, timer 0. Outputs after reset: detect_add=1 and every other output 0.
- All outputs are registered-state decodes. Inputs take effect on the next clock edge.
- Header on cycle 0 with an empty FIFO: lfd_state=1 in cycle 1 and ld_state=1 in cycle 2.
- fifofull sampled high in LD: full_state=1 next cycle. we_en_reg drops in the same cycle.
- addr_err is high during the first DROP cycle only.
- timeout_err is high during the first DROP cycle entered via timeout only.
- srst has a one-cycle effect: detect_add=1 in the following cycle.
- Simultaneous parity_done and lowpktvalid in LAF: parity_done wins.

## Configuration
- ROUTER_WAIT_TIMEOUT_EN, when defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) clears on entry to WAIT_TILL_EMPTY and increments each cycle spent there.
  - When the count reaches TIMEOUT_CYC and fifoempty[addr] is still 0, the FSM goes to DROP and pulses timeout_err.
  - fifoempty[addr] arriving in the same cycle as expiry wins, and the FSM goes to LFD.
- ROUTER_WAIT_TIMEOUT_EN undefined: no counter is built, WAIT_TILL_EMPTY waits indefinitely, and timeout_err is constant 0.

## Structure
- Package router_pkg: state enum/localparams, the default NCH, and a onehot function.
- Sub-module router_wait_timer (counter, clear, expiry flag), instantiated only under ROUTER_WAIT_TIMEOUT_EN.

## Test plan
- NCH=3, header din=2 with fifoempty=3'b111 -> LFD, then LD; wr_sel=3'b100 in both; we_en_reg=1 from LD.
- Header din=1 with fifoempty[1]=0 -> busy=1 in WAIT_TILL_EMPTY; after fifoempty[1] rises -> LFD the next cycle.
- Header din=3 with NCH=3 -> addr_err pulse, DROP, busy=0 while pktvalid=1; pktvalid low -> DECODE_ADD.
- In LD, fifofull=1 for 4 cycles -> full_state for 4 cycles, then LAF. In LAF, parity_done=1 with lowpktvalid=1 -> DECODE_ADD.
- In LD with addr=0, srst=3'b010 -> no effect. Then srst=3'b001 -> detect_add=1 next cycle, wr_sel=0.
- Macro defined, TIMEOUT_CYC=8, fifoempty[0] held 0 -> timeout_err pulse after 8 wait cycles, then DROP.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and helpers for the router write-side control FSM.
package router_pkg;

    localparam int DEF_NCH = 3;
    localparam int MAX_NCH = 8;

    typedef enum logic [3:0] {
        DECODE_ADD      = 4'd0,
        LFD             = 4'd1,
        LD              = 4'd2,
        FFS             = 4'd3,
        LAF             = 4'd4,
        LP              = 4'd5,
        CPERROR         = 4'd6,
        WAIT_TILL_EMPTY = 4'd7,
        DROP            = 4'd8
    } state_e;

    // One-hot channel select, sized for the largest supported router.
    function automatic logic [MAX_NCH-1:0] onehot(input int unsigned idx);
        logic [MAX_NCH-1:0] v;
        v = '0;
        if (idx < MAX_NCH) begin
            v[idx[2:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Wait-till-empty timeout counter: counts cycles while not cleared and flags
// the cycle on which the count is about to reach CYC.
module router_wait_timer #(
    parameter int CYC = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic expired
);

    localparam int W = $clog2(CYC + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (count != W'(CYC)) begin
            count <= count + 1'b1;
        end
    end

    // Expiry is taken on the edge that would bring the count up to CYC.
    assign expired = (count == W'(CYC - 1));

endmodule

// File: rtl/router_ctrl_fsm_n.sv
// Write-side control FSM for an N-channel packet router.
// Optional wait-till-empty timeout enabled by defining ROUTER_WAIT_TIMEOUT_EN.
module router_ctrl_fsm_n
    import router_pkg::*;
#(
    parameter int NCH         = DEF_NCH,
    parameter int ADDR_W      = 2,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pktvalid,
    input  logic [ADDR_W-1:0] din,
    input  logic              fifofull,
    input  logic [NCH-1:0]    fifoempty,
    input  logic [NCH-1:0]    srst,
    input  logic              parity_done,
    input  logic              lowpktvalid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              we_en_reg,
    output logic              rst_int_reg,
    output logic              busy,
    output logic [NCH-1:0]    wr_sel,
    output logic              addr_err,
    output logic              timeout_err
);

    localparam int              NA    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] NCH_X = (ADDR_W + 1)'(NCH);

    if (NCH < 2 || NCH > MAX_NCH || NA < NCH || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("router_ctrl_fsm_n: illegal parameter combination");
    end

    // Handshake: pktvalid qualifies din on every cycle; while busy is high the
    // source must hold its byte, and bytes seen with busy low in DROP are discarded.

    state_e            state, next_state;
    logic [ADDR_W-1:0] addr, addr_d;
    logic              addr_err_q, addr_err_d;
    logic [NA-1:0]     fe_pad, srst_pad;
    logic              fe_din, fe_sel, srst_hit;
    logic [MAX_NCH-1:0] oh;

    // Pad per-channel vectors so any address value indexes safely.
    assign fe_pad   = NA'(fifoempty);
    assign srst_pad = NA'(srst);
    assign fe_din   = fe_pad[din];
    assign fe_sel   = fe_pad[addr];
    assign srst_hit = (state != DECODE_ADD) && srst_pad[addr];

`ifdef ROUTER_WAIT_TIMEOUT_EN
    logic timer_clr, expired, timeout_err_q, timeout_err_d;

    assign timer_clr = (state != WAIT_TILL_EMPTY) || srst_hit;

    router_wait_timer #(.CYC(TIMEOUT_CYC)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= DECODE_ADD;
            addr       <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state      <= next_state;
            addr       <= addr_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_comb begin
        next_state = state;
        addr_d     = addr;
        addr_err_d = 1'b0;
`ifdef ROUTER_WAIT_TIMEOUT_EN
        timeout_err_d = 1'b0;
`endif
        case (state)
            DECODE_ADD: begin
                if (pktvalid) begin
                    addr_d = din;
                    if ({1'b0, din} >= NCH_X) begin
                        next_state = DROP;
                        addr_err_d = 1'b1;
                    end else if (fe_din) begin
                        next_state = LFD;
                    end else begin
                        next_state = WAIT_TILL_EMPTY;
                    end
                end
            end
            LFD: next_state = LD;
            LD: begin
                if (fifofull) begin
                    next_state = FFS;
                end else if (!pktvalid) begin
                    next_state = LP;
                end
            end
            FFS: begin
                if (!fifofull) begin
                    next_state = LAF;
                end
            end
            LAF: begin
                if (parity_done) begin
                    next_state = DECODE_ADD;
                end else if (lowpktvalid) begin
                    next_state = LP;
                end else begin
                    next_state = LD;
                end
            end
            LP: next_state = CPERROR;
            CPERROR: next_state = fifofull ? FFS : DECODE_ADD;
            WAIT_TILL_EMPTY: begin
                // An empty FIFO arriving on the expiry cycle still wins.
                if (fe_sel) begin
                    next_state = LFD;
                end
`ifdef ROUTER_WAIT_TIMEOUT_EN
                else if (expired) begin
                    next_state    = DROP;
                    timeout_err_d = 1'b1;
                end
`endif
            end
            DROP: begin
                if (!pktvalid) begin
                    next_state = DECODE_ADD;
                end
            end
            default: next_state = DECODE_ADD;
        endcase

        if (srst_hit) begin
            next_state = DECODE_ADD;
            addr_d     = '0;
            addr_err_d = 1'b0;
`ifdef ROUTER_WAIT_TIMEOUT_EN
            timeout_err_d = 1'b0;
`endif
        end
    end

    always_comb begin
        oh          = onehot(32'(addr));
        detect_add  = (state == DECODE_ADD);
        lfd_state   = (state == LFD);
        ld_state    = (state == LD);
        laf_state   = (state == LAF);
        full_state  = (state == FFS);
        rst_int_reg = (state == CPERROR);
        we_en_reg   = (state inside {LD, LAF, LP});
        busy        = (state inside {LFD, FFS, LAF, LP, CPERROR, WAIT_TILL_EMPTY});
        wr_sel      = '0;
        if (state inside {LFD, LD, LAF, LP}) begin
            wr_sel = oh[NCH-1:0];
        end
    end

    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_router_ctrl_fsm_n.sv
// Self-checking bench for router_ctrl_fsm_n (NCH=3, ADDR_W=2, TIMEOUT_CYC=8).
module tb_router_ctrl_fsm_n;

    localparam int NCH    = 3;
    localparam int ADDR_W = 2;
    localparam int TCYC   = 8;

    localparam int S_DEC  = 0;
    localparam int S_LFD  = 1;
    localparam int S_LD   = 2;
    localparam int S_FFS  = 3;
    localparam int S_LAF  = 4;
    localparam int S_LP   = 5;
    localparam int S_CP   = 6;
    localparam int S_WAIT = 7;
    localparam int S_DROP = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              pktvalid;
    logic [ADDR_W-1:0] din;
    logic              fifofull;
    logic [NCH-1:0]    fifoempty;
    logic [NCH-1:0]    srst;
    logic              parity_done;
    logic              lowpktvalid;
    logic              detect_add, lfd_state, ld_state, laf_state, full_state;
    logic              we_en_reg, rst_int_reg, busy;
    logic [NCH-1:0]    wr_sel;
    logic              addr_err, timeout_err;
    logic [12:0]       obs;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [12:0] exp_q[$];
    string       tag_q[$];

    router_ctrl_fsm_n #(
        .NCH         (NCH),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TCYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pktvalid    (pktvalid),
        .din         (din),
        .fifofull    (fifofull),
        .fifoempty   (fifoempty),
        .srst        (srst),
        .parity_done (parity_done),
        .lowpktvalid (lowpktvalid),
        .detect_add  (detect_add),
        .lfd_state   (lfd_state),
        .ld_state    (ld_state),
        .laf_state   (laf_state),
        .full_state  (full_state),
        .we_en_reg   (we_en_reg),
        .rst_int_reg (rst_int_reg),
        .busy        (busy),
        .wr_sel      (wr_sel),
        .addr_err    (addr_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    assign obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                  we_en_reg, rst_int_reg, busy, wr_sel, addr_err, timeout_err};

    // Expected output word for a given state from the output decode table.
    function automatic logic [12:0] ev(input int st, input int ch, input logic aerr, input logic terr);
        logic [2:0] ws;
        logic       we, bz;
        ws = '0;
        if (st == S_LFD || st == S_LD || st == S_LAF || st == S_LP) ws[ch] = 1'b1;
        we = (st == S_LD || st == S_LAF || st == S_LP);
        bz = (st == S_LFD || st == S_FFS || st == S_LAF || st == S_LP || st == S_CP || st == S_WAIT);
        return {st == S_DEC, st == S_LFD, st == S_LD, st == S_LAF, st == S_FFS,
                we, st == S_CP, bz, ws, aerr, terr};
    endfunction

    task automatic check_eq(input string tag, input logic [12:0] got, input logic [12:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got=%b want=%b", tag, got, want);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs after the edge, compare.
    task automatic drive(input logic pv, input logic [1:0] d, input logic ff,
                         input logic [2:0] fe, input logic [2:0] sr, input logic pd,
                         input logic lpv, input int st, input int ch,
                         input logic aerr, input logic terr, input string tag);
        logic [12:0] want;
        string       t;
        pktvalid    = pv;
        din         = d;
        fifofull    = ff;
        fifoempty   = fe;
        srst        = sr;
        parity_done = pd;
        lowpktvalid = lpv;
        exp_q.push_back(ev(st, ch, aerr, terr));
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        check_eq(t, obs, want);
    endtask

    initial begin
        rst         = 1'b0;
        pktvalid    = 1'b0;
        din         = '0;
        fifofull    = 1'b0;
        fifoempty   = 3'b111;
        srst        = '0;
        parity_done = 1'b0;
        lowpktvalid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("reset", obs, ev(S_DEC, 0, 1'b0, 1'b0));
        drive(1, 2, 0, 3'b111, 0, 0, 0, S_DEC, 0, 0, 0, "reset_hold");
        rst = 1'b1;

        // Header to empty FIFO 2, short packet ending from LD
        drive(1, 2, 0, 3'b111, 0, 0, 0, S_LFD, 2, 0, 0, "t1_lfd");
        drive(1, 0, 0, 3'b111, 0, 0, 0, S_LD,  2, 0, 0, "t1_ld");
        drive(1, 0, 0, 3'b111, 0, 0, 0, S_LD,  2, 0, 0, "t1_ld_hold");
        drive(0, 0, 0, 3'b111, 0, 0, 0, S_LP,  2, 0, 0, "t1_lp");
        drive(0, 0, 0, 3'b111, 0, 0, 0, S_CP,  0, 0, 0, "t1_cperr");
        drive(0, 0, 0, 3'b111, 0, 0, 0, S_DEC, 0, 0, 0, "t1_done");

        // Wait for FIFO 1 to drain, then full stall and parity priority
        drive(1, 1, 0, 3'b101, 0, 0, 0, S_WAIT, 0, 0, 0, "t2_wait");
        drive(1, 0, 0, 3'b101, 0, 0, 0, S_WAIT, 0, 0, 0, "t2_wait_hold");
        drive(1, 0, 0, 3'b111, 0, 0, 0, S_LFD,  1, 0, 0, "t2_lfd");
        drive(1, 0, 0, 3'b111, 0, 0, 0, S_LD,   1, 0, 0, "t2_ld");
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 3'b111, 0, 0, 0, S_FFS, 0, 0, 0, "t2_full");
        end
        drive(1, 0, 0, 3'b111, 0, 0, 0, S_LAF, 1, 0, 0, "t2_laf");
        drive(1, 0, 0, 3'b111, 0, 1, 1, S_DEC, 0, 0, 0, "t2_parity_wins");

        // Invalid address drop
        drive(1, 3, 0, 3'b111, 0, 0, 0, S_DROP, 0, 1, 0, "t3_addr_err");
        drive(1, 0, 0, 3'b111, 0, 0, 0, S_DROP, 0, 0, 0, "t3_drop_hold");
        drive(0, 0, 0, 3'b111, 0, 0, 0, S_DEC,  0, 0, 0, "t3_drop_exit");

        // Soft reset: other channel ignored, own channel aborts
        drive(1, 0, 0, 3'b111, 0,      0, 0, S_LFD, 0, 0, 0, "t4_lfd");
        drive(1, 0, 0, 3'b111, 0,      0, 0, S_LD,  0, 0, 0, "t4_ld");
        drive(1, 0, 0, 3'b111, 3'b010, 0, 0, S_LD,  0, 0, 0, "t4_srst_other");
        drive(1, 0, 0, 3'b111, 3'b001, 0, 0, S_DEC, 0, 0, 0, "t4_srst_own");
        drive(0, 0, 0, 3'b111, 3'b001, 0, 0, S_DEC, 0, 0, 0, "t4_srst_idle");

        // lowpktvalid path and CPERROR back into a full stall
        drive(1, 2, 0, 3'b111, 0, 0, 0, S_LFD, 2, 0, 0, "t5_lfd");
        drive(1, 0, 0, 3'b111, 0, 0, 0, S_LD,  2, 0, 0, "t5_ld");
        drive(1, 0, 1, 3'b111, 0, 0, 0, S_FFS, 0, 0, 0, "t5_ffs");
        drive(1, 0, 0, 3'b111, 0, 0, 0, S_LAF, 2, 0, 0, "t5_laf");
        drive(0, 0, 0, 3'b111, 0, 0, 1, S_LP,  2, 0, 0, "t5_lowpkt");
        drive(0, 0, 0, 3'b111, 0, 0, 0, S_CP,  0, 0, 0, "t5_cperr");
        drive(0, 0, 1, 3'b111, 0, 0, 0, S_FFS, 0, 0, 0, "t5_cperr_full");
        drive(0, 0, 0, 3'b111, 0, 0, 0, S_LAF, 2, 0, 0, "t5_laf2");
        drive(1, 0, 0, 3'b111, 0, 0, 0, S_LD,  2, 0, 0, "t5_laf_to_ld");
        drive(0, 0, 0, 3'b111, 0, 0, 0, S_LP,  2, 0, 0, "t5_lp");
        drive(0, 0, 0, 3'b111, 0, 0, 0, S_CP,  0, 0, 0, "t5_cperr2");
        drive(0, 0, 0, 3'b111, 0, 0, 0, S_DEC, 0, 0, 0, "t5_done");

        // Random headers against random FIFO empty flags
        for (int i = 0; i < 10; i++) begin
            logic [1:0] rd;
            logic [2:0] rfe;
            rd  = 2'($urandom_range(0, 3));
            rfe = 3'($urandom_range(0, 7));
            if (rd == 2'd3) begin
                drive(1, rd, 0, rfe, 0, 0, 0, S_DROP, 0, 1, 0, "rnd_drop");
                drive(0, 0,  0, rfe, 0, 0, 0, S_DEC,  0, 0, 0, "rnd_drop_exit");
            end else if (rfe[rd]) begin
                drive(1, rd, 0, rfe, 0, 0, 0, S_LFD, int'(rd), 0, 0, "rnd_lfd");
                drive(0, 0,  0, rfe, 0, 0, 0, S_LD,  int'(rd), 0, 0, "rnd_ld");
                drive(0, 0,  0, rfe, 0, 0, 0, S_LP,  int'(rd), 0, 0, "rnd_lp");
                drive(0, 0,  0, rfe, 0, 0, 0, S_CP,  0, 0, 0, "rnd_cperr");
                drive(0, 0,  0, rfe, 0, 0, 0, S_DEC, 0, 0, 0, "rnd_done");
            end else begin
                drive(1, rd, 0, rfe, 0, 0, 0, S_WAIT, 0, 0, 0, "rnd_wait");
                drive(0, 0,  0, rfe, 3'(1 << rd), 0, 0, S_DEC, 0, 0, 0, "rnd_wait_srst");
            end
        end

`ifdef ROUTER_WAIT_TIMEOUT_EN
        // Timeout: eight wait cycles, then DROP with timeout_err
        drive(1, 0, 0, 3'b110, 0, 0, 0, S_WAIT, 0, 0, 0, "to_wait");
        for (int i = 0; i < TCYC - 1; i++) begin
            drive(1, 0, 0, 3'b110, 0, 0, 0, S_WAIT, 0, 0, 0, "to_wait_hold");
        end
        drive(1, 0, 0, 3'b110, 0, 0, 0, S_DROP, 0, 0, 1, "to_expire");
        drive(1, 0, 0, 3'b110, 0, 0, 0, S_DROP, 0, 0, 0, "to_drop_hold");
        drive(0, 0, 0, 3'b110, 0, 0, 0, S_DEC,  0, 0, 0, "to_drop_exit");

        // Empty flag on the expiry cycle wins
        drive(1, 0, 0, 3'b110, 0, 0, 0, S_WAIT, 0, 0, 0, "tie_wait");
        for (int i = 0; i < TCYC - 1; i++) begin
            drive(1, 0, 0, 3'b110, 0, 0, 0, S_WAIT, 0, 0, 0, "tie_wait_hold");
        end
        drive(1, 0, 0, 3'b111, 0, 0, 0, S_LFD, 0, 0, 0, "tie_empty_wins");
        drive(0, 0, 0, 3'b111, 0, 0, 0, S_LD,  0, 0, 0, "tie_ld");
        drive(0, 0, 0, 3'b111, 0, 0, 0, S_LP,  0, 0, 0, "tie_lp");
        drive(0, 0, 0, 3'b111, 0, 0, 0, S_CP,  0, 0, 0, "tie_cperr");
        drive(0, 0, 0, 3'b111, 0, 0, 0, S_DEC, 0, 0, 0, "tie_done");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
